// File: rtl/gray_pkg.sv
// Shared types for the Gray-code switch conditioner.
// Holds the FSM state encoding, the Gray word type and a popcount helper.
package gray_pkg;

  localparam int GRAY_WIDTH = 4;

  typedef enum logic {STABLE, SETTLE} cond_state_t;

  typedef logic [GRAY_WIDTH-1:0] gray_t;

  // Number of set bits; used to tell a single Gray step from a jump
  function automatic int unsigned popcount32(input logic [31:0] v);
    int unsigned n;
    n = 0;
    for (int i = 0; i < 32; i++) begin
      n += {31'd0, v[i]};
    end
    return n;
  endfunction

endpackage

// File: rtl/sync_ff_chain.sv
// Plain multi-flop synchroniser for asynchronous level inputs.
// No logic between stages so every bit gets full resolution time.
module sync_ff_chain #(
  parameter int WIDTH  = 1,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] ff_q [STAGES];

  // Shift the async level through the flop chain
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < STAGES; i++) begin
        ff_q[i] <= '0;
      end
    end else begin
      ff_q[0] <= d;
      for (int i = 1; i < STAGES; i++) begin
        ff_q[i] <= ff_q[i-1];
      end
    end
  end

  assign q = ff_q[STAGES-1];

endmodule

// File: rtl/gray_input_conditioner.sv
// Synchronises and debounces the Gray switch bank as one vector.
// Commits stable values to gray_out and flags multi-bit jumps.
module gray_input_conditioner
  import gray_pkg::*;
#(
  parameter int WIDTH           = 4,
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 270000
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] sw_in,
  output logic [WIDTH-1:0] gray_out,
  output logic             gray_valid,
  output logic             step_err,
  output logic             busy
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic [WIDTH-1:0] s;
  logic [WIDTH-1:0] cand_q;
  logic [WIDTH-1:0] gray_q;
  logic [CW-1:0]    cnt_q;
  logic             valid_q;
  logic             err_q;
  cond_state_t      state_q;
  logic [WIDTH-1:0] diff;

  sync_ff_chain #(
    .WIDTH  (WIDTH),
    .STAGES (SYNC_STAGES)
  ) u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (sw_in),
    .q     (s)
  );

  assign diff = cand_q ^ gray_q;

  // Debounce FSM: track a candidate, commit after a quiet window
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= STABLE;
      cand_q  <= '0;
      gray_q  <= '0;
      cnt_q   <= '0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      err_q   <= 1'b0;
      unique case (state_q)
        STABLE: begin
          if (s != gray_q) begin
            cand_q  <= s;
            cnt_q   <= '0;
            state_q <= SETTLE;
          end
        end
        SETTLE: begin
          if (s != cand_q) begin
            cand_q <= s;
            cnt_q  <= '0;
          end else if (cnt_q == CNT_LAST) begin
            state_q <= STABLE;
            cnt_q   <= '0;
            if (cand_q != gray_q) begin
              gray_q  <= cand_q;
              valid_q <= 1'b1;
              err_q   <= popcount32(32'(diff)) != 1;
            end
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        default: state_q <= STABLE;
      endcase
    end
  end

  assign gray_out   = gray_q;
  assign gray_valid = valid_q;
  assign step_err   = err_q;
  assign busy       = (state_q == SETTLE);

endmodule

// File: tb/tb_gray_input_conditioner.sv
// Scoreboard bench for gray_input_conditioner.
// DEBOUNCE_CYCLES=4, SYNC_STAGES=2; inputs driven on the falling edge.
module tb_gray_input_conditioner;
  import gray_pkg::*;

  localparam int DB  = 4;
  localparam int SS  = 2;
  // Drive at negedge of cycle N -> gray_valid seen at negedge of N+LAT
  localparam int LAT = SS + DB + 1;

  typedef struct {
    int unsigned at;
    gray_t       val;
    logic        err;
  } exp_t;

  logic  clk;
  logic  rst_n;
  gray_t sw_in;
  gray_t gray_out;
  logic  gray_valid;
  logic  step_err;
  logic  busy;

  int unsigned cyc;
  int          n_tests;
  int          n_fail;
  exp_t        sbq [$];
  exp_t        mon_e;

  gray_input_conditioner #(
    .WIDTH           (4),
    .SYNC_STAGES     (SS),
    .DEBOUNCE_CYCLES (DB)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .sw_in      (sw_in),
    .gray_out   (gray_out),
    .gray_valid (gray_valid),
    .step_err   (step_err),
    .busy       (busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic push_commit(input gray_t v, input logic e);
    exp_t x;
    x.at  = cyc + LAT;
    x.val = v;
    x.err = e;
    sbq.push_back(x);
  endtask

  // Monitor: every commit must match the head of the scoreboard
  always @(negedge clk) begin
    check("err_wo_valid", {31'd0, step_err & ~gray_valid}, 32'd0);
    if (gray_valid) begin
      if (sbq.size() == 0) begin
        check("spurious_valid", {31'd0, gray_valid}, 32'd0);
      end else begin
        mon_e = sbq.pop_front();
        check("commit_val", {28'd0, gray_out}, {28'd0, mon_e.val});
        check("commit_err", {31'd0, step_err}, {31'd0, mon_e.err});
        check("commit_cyc", cyc, mon_e.at);
      end
    end
  end

  initial begin
    #20000;
    $display("FAIL timeout got=%0d exp=done", cyc);
    $fatal(1, "timeout");
  end

  initial begin
    cyc     = 0;
    n_tests = 0;
    n_fail  = 0;
    rst_n   = 1'b0;
    sw_in   = 4'b1010;

    // Reset hold with a non-zero input
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("rst_out",   {28'd0, gray_out},   32'd0);
      check("rst_valid", {31'd0, gray_valid}, 32'd0);
      check("rst_err",   {31'd0, step_err},   32'd0);
      check("rst_busy",  {31'd0, busy},       32'd0);
    end
    rst_n = 1'b1;
    push_commit(4'b1010, 1'b1);
    cycles(12);
    check("post_rst_out", {28'd0, gray_out}, 32'h0000_000a);

    // Back to zero (two-bit jump)
    sw_in = 4'b0000;
    push_commit(4'b0000, 1'b1);
    cycles(12);

    // Clean single-bit step
    sw_in = 4'b0001;
    push_commit(4'b0001, 1'b0);
    cycles(2);
    check("clean_busy_lo", {31'd0, busy}, 32'd0);
    cycles(1);
    check("clean_busy_hi", {31'd0, busy}, 32'd1);
    cycles(9);
    check("clean_out", {28'd0, gray_out}, 32'd1);

    // Bounce 0001<->0011, then settle on 0011
    for (int i = 0; i < 5; i++) begin
      sw_in = (i % 2 == 0) ? 4'b0011 : 4'b0001;
      if (i < 4) cycles(2);
    end
    push_commit(4'b0011, 1'b0);
    cycles(4);
    check("bounce_hold", {28'd0, gray_out}, 32'd1);
    cycles(8);
    check("bounce_out", {28'd0, gray_out}, 32'd3);

    // Glitch that returns to the committed value
    sw_in = 4'b0111;
    cycles(2);
    sw_in = 4'b0011;
    cycles(1);
    check("glitch_busy", {31'd0, busy}, 32'd1);
    cycles(11);
    check("glitch_out",  {28'd0, gray_out}, 32'd3);
    check("glitch_idle", {31'd0, busy},     32'd0);

    // Illegal multi-bit step still commits
    sw_in = 4'b1100;
    push_commit(4'b1100, 1'b1);
    cycles(12);
    check("illegal_out", {28'd0, gray_out}, 32'h0000_000c);

    // Reset while debouncing with cnt=2
    sw_in = 4'b1101;
    cycles(5);
    check("mid_busy", {31'd0, busy}, 32'd1);
    rst_n = 1'b0;
    sw_in = 4'b0000;
    cycles(1);
    check("mid_rst_busy",  {31'd0, busy},       32'd0);
    check("mid_rst_out",   {28'd0, gray_out},   32'd0);
    check("mid_rst_valid", {31'd0, gray_valid}, 32'd0);
    cycles(1);
    rst_n = 1'b1;
    cycles(12);
    check("final_out", {28'd0, gray_out}, 32'd0);
    check("sb_empty", sbq.size(), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
